// File: rtl/decode_pkg.sv
// Shared types and elaboration-time checks for the decode pipeline.
package decode_pkg;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   localparam int IN_W_MAX = 8;

   function automatic bit widths_ok(input int in_w, input int out_w);
      return (in_w >= 1) && (in_w <= IN_W_MAX) && (out_w >= 2) && (out_w <= (1 << in_w));
   endfunction

endpackage

// File: rtl/decode_pipe_core.sv
// Combinational binary code -> one-hot (or thermometer with DECODE_THERMO_EN) plus range error.
module decode_core #(
   parameter int IN_W  = 3,
   parameter int OUT_W = 8
) (
   input  logic [IN_W-1:0]  code,
`ifdef DECODE_THERMO_EN
   input  logic             thermo,
`endif
   output logic [OUT_W-1:0] y,
   output logic             err
);

   // One extra bit so OUT_W == 2**IN_W is representable without aliasing to zero.
   localparam logic [IN_W:0] LIMIT = (IN_W + 1)'(OUT_W);

   logic [IN_W:0] code_x;
   assign code_x = {1'b0, code};

   always_comb begin
      err = (code_x >= LIMIT);
      y   = '0;
      for (int i = 0; i < OUT_W; i++) begin
`ifdef DECODE_THERMO_EN
         y[i] = thermo ? (code_x >= (IN_W + 1)'(i)) : (code_x == (IN_W + 1)'(i));
`else
         y[i] = (code_x == (IN_W + 1)'(i));
`endif
      end
   end

endmodule

// File: rtl/decode_pipe.sv
// Registered decoder with 2-entry skid output stage; in_ready is a flop, independent of out_ready.
// Optional thermometer decode enabled by DECODE_THERMO_EN.
module decode_pipe
   import decode_pkg::*;
#(
   parameter int IN_W  = 3,
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
`ifdef DECODE_THERMO_EN
   input  logic             in_thermo,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_y,
   output logic             out_err
);

   generate
      if (!widths_ok(IN_W, OUT_W)) begin : g_bad_widths
         $error("decode_pipe: illegal IN_W/OUT_W combination");
      end
   endgenerate

   typedef struct packed {
      logic [OUT_W-1:0] y;
      logic             err;
   } res_t;

   state_t           state_q, state_d;
   res_t             main_q, main_d;
   res_t             skid_q, skid_d;
   res_t             dec;
   logic             in_ready_q, in_ready_d;
   logic [OUT_W-1:0] dec_y;
   logic             dec_err;
   logic             accept;

   decode_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .code   (in_data),
`ifdef DECODE_THERMO_EN
      .thermo (in_thermo),
`endif
      .y      (dec_y),
      .err    (dec_err)
   );

   assign dec    = '{y: dec_y, err: dec_err};
   assign accept = in_valid && in_ready_q;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               main_d  = dec;
            end
         end
         ONE: begin
            if (accept && out_ready) begin
               main_d = dec;
            end else if (accept) begin
               state_d = TWO;
               skid_d  = dec;
            end else if (out_ready) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            // in_ready is low here, so no new code can arrive this cycle.
            if (out_ready) begin
               state_d = ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      in_ready_d = (state_d != TWO);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != EMPTY);
   assign out_y     = main_q.y;
   assign out_err   = main_q.err;

endmodule
